sem_supervisor: RTL and testbench
=================================

Name: sem_supervisor

Overview:
Sequences and monitors the FPGA soft-error-mitigation (SEM) core exposed through the board reserved interface. Drives `sem_enable` and decodes the 14-bit `sem_status` vector. Tracks SEM state, heartbeat liveness and corrected/uncorrectable error events, and publishes counters, sticky flags and an interrupt to the management register block. Sits in the board top, between the reserved in/out structs and the host CSR space.

Parameters:
- ENABLE_DELAY_C, 1024: cycles after `sw_enable` rises before `sem_enable` asserts.
- INIT_TIMEOUT_C, 2^24: max cycles from `sem_enable` to observation state.
- HB_TIMEOUT_C, 4096: max cycles between heartbeat edges while observing.
- CNT_W_C, 16: width of the event counters (saturating).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset. Synchronous, active-high.
- sw_enable, input, 1: software request to run SEM (level).
- clr_stats, input, 1: one-cycle pulse. Clears counters, sticky flags and irq.
- sem_status, input, 14: SEM status bits.
  - [0] init, [1] observation, [2] correction, [3] classification, [4] injection.
  - [5] idle, [6] fatal, [7] heartbeat, [8] essential, [9] uncorrectable, [10] corrected.
  - [13:11] reserved, ignored.
- sem_enable, output, 1: drives top_reserved_out_t.sem_enable.
- state, output, 3: current FSM state encoding.
- corr_count, output, CNT_W_C: corrected-error events.
- uncorr_count, output, CNT_W_C: uncorrectable-error events.
- init_timeout, output, 1: sticky flag.
- hb_timeout, output, 1: sticky flag.
- fatal_seen, output, 1: sticky flag.
- irq, output, 1: level interrupt. Set on any sticky flag rising or on an uncorrectable event.

Behaviour:
- Reset values: every output is 0 and the FSM is in OFF. Counters, flags and timers all clear.
- Input handling: `sem_status` is registered once (s1). Edge detection compares s1 with s2. All decisions use s1, giving 2-cycle latency from pin to reaction.
- FSM encodings:
  - OFF=0: `sem_enable`=0.
  - DELAY=1: counts ENABLE_DELAY_C cycles, `sem_enable`=0.
  - INIT=2: `sem_enable`=1, init timer runs.
  - OBSERVE=3: `sem_enable`=1, heartbeat watchdog runs.
  - FAULT=4: `sem_enable`=1, latched and waiting for software.
- Transitions:
  - OFF -> DELAY when `sw_enable`=1.
  - DELAY -> INIT when the delay count reaches ENABLE_DELAY_C-1. `sem_enable` rises in the first INIT cycle.
  - INIT -> OBSERVE on s1[1]=1.
  - INIT -> FAULT when the init timer reaches INIT_TIMEOUT_C-1; sets `init_timeout`.
  - OBSERVE -> FAULT when the watchdog reaches HB_TIMEOUT_C-1 without a heartbeat rising edge; sets `hb_timeout`.
  - Any of INIT/OBSERVE -> FAULT on s1[6]; sets `fatal_seen`. Fatal takes priority over timeout in the same cycle.
  - OBSERVE <-> correction/classification/injection phases (s1[2..4]) do not leave OBSERVE. The watchdog is held at 0 while any of s1[2..4] is set.
  - `sw_enable`=0 in any state -> OFF next cycle, `sem_enable`=0. It is checked before all other transitions.
  - FAULT -> OFF only via `sw_enable`=0.
- Watchdog reset: cleared on each heartbeat rising edge (s1[7] & ~s2[7]).
- Counters:
  - `corr_count` increments on each s1[10] rising edge.
  - `uncorr_count` increments on each s1[9] rising edge, only in INIT/OBSERVE/FAULT.
  - Both saturate at all-ones and never wrap.
- `clr_stats`:
  - Zeroes counters, sticky flags and irq. Does not change FSM state.
  - If an event edge coincides with `clr_stats`, the counter ends at 1. A flag set in the same cycle stays set: set wins.
- Timers: sized to clog2 of their limit and clear on state entry.

Optional Feature:
- Macro: SEM_SUPERVISOR_AUTO_RESTART_EN.
- With the macro defined: an hb_timeout in OBSERVE goes to DELAY instead of FAULT. `sem_enable` drops for the full ENABLE_DELAY_C window, then re-arms. `hb_timeout` is still set and irq still asserts.
  - Restarts are limited to 3 consecutive. A 4th timeout before `clr_stats` goes to FAULT.
  - An extra 2-bit `restart_count` output reports attempts and is cleared by `clr_stats`.
- Without the macro: hb_timeout always enters FAULT. The `restart_count` port does not exist.

Test Plan:
- Bring-up:
  - Stimulus: ENABLE_DELAY_C=16, `sw_enable` rises at cycle 0, s1[1] rises at cycle 40 of INIT.
  - Required: `sem_enable`=1 at cycle 17, `state`=3 two cycles after status[1] rises, flags all 0.
- Heartbeat watchdog:
  - Stimulus: HB_TIMEOUT_C=64, heartbeat toggles every 32 cycles.
  - Required: stays in OBSERVE.
  - Stimulus: heartbeat stops.
  - Required: `state`=4, `hb_timeout`=1, irq=1 exactly 64 cycles after the last edge plus 2 cycles input latency.
- Counting and saturation:
  - Stimulus: CNT_W_C=4, 20 corrected pulses.
  - Required: `corr_count`=15.
  - Stimulus: `clr_stats` coincident with a 21st pulse.
  - Required: `corr_count`=1.
- Fatal priority:
  - Stimulus: status[6] and init timeout both occur in the same cycle while in INIT.
  - Required: `fatal_seen`=1 and `init_timeout`=1; `state`=4.
  - Stimulus: `sw_enable`=0.
  - Required: `state`=0 and `sem_enable`=0 next cycle.
- Mid-operation reset:
  - Stimulus: `rst` pulsed for 1 cycle in OBSERVE with nonzero counters.
  - Required: all outputs 0 next cycle. With `sw_enable` still 1, the FSM re-enters DELAY the following cycle.
- Auto-restart (macro defined):
  - Stimulus: 3 heartbeat timeouts.
  - Required: `restart_count`=3 and `sem_enable` re-asserts each time.
  - Stimulus: 4th heartbeat timeout.
  - Required: `state`=4.

Source files
------------

// File: rtl/sem_supervisor.sv
// sem_supervisor: sequences the SEM core and monitors its status, optional auto-restart via SEM_SUPERVISOR_AUTO_RESTART_EN
module sem_supervisor #(
    parameter int ENABLE_DELAY_C = 1024,
    parameter int INIT_TIMEOUT_C = 2**24,
    parameter int HB_TIMEOUT_C   = 4096,
    parameter int CNT_W_C        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_enable,
    input  logic               clr_stats,
    input  logic [13:0]        sem_status,
    output logic               sem_enable,
    output logic [2:0]         state,
    output logic [CNT_W_C-1:0] corr_count,
    output logic [CNT_W_C-1:0] uncorr_count,
    output logic               init_timeout,
    output logic               hb_timeout,
    output logic               fatal_seen,
`ifdef SEM_SUPERVISOR_AUTO_RESTART_EN
    output logic [1:0]         restart_count,
`endif
    output logic               irq
);
    localparam int DW = ENABLE_DELAY_C > 1 ? $clog2(ENABLE_DELAY_C) : 1;
    localparam int IW = INIT_TIMEOUT_C > 1 ? $clog2(INIT_TIMEOUT_C) : 1;
    localparam int HW = HB_TIMEOUT_C > 1 ? $clog2(HB_TIMEOUT_C) : 1;
    typedef enum logic [2:0] {OFF = 3'd0, DELAY = 3'd1, INIT = 3'd2, OBSERVE = 3'd3, FAULT = 3'd4} state_t;
    state_t st, st_nx;
    logic [10:0] s1;
    logic [2:0] s2;
    logic [DW-1:0] dly_cnt;
    logic [IW-1:0] init_cnt;
    logic [HW-1:0] wd_cnt;
    logic hb_edge, phase, cor_evt, unc_evt, fatal_set, init_set, hb_set, restart, unused_bits;
`ifndef SEM_SUPERVISOR_AUTO_RESTART_EN
    logic [1:0] restart_count;
`endif
    assign hb_edge     = s1[7] & ~s2[0];
    assign phase       = |s1[4:2];
    assign cor_evt     = s1[10] & ~s2[2];
    assign unc_evt     = s1[9] & ~s2[1] & (st == INIT || st == OBSERVE || st == FAULT);
    assign sem_enable  = st == INIT || st == OBSERVE || st == FAULT;
    assign state       = st;
    assign unused_bits = ^{sem_status[13:11], s1[8], s1[5], s1[0], restart_count};
    // next state and flag-set events; software disable overrides everything, fatal outranks timeouts
    always_comb begin
        st_nx     = st;
        fatal_set = 1'b0;
        init_set  = 1'b0;
        hb_set    = 1'b0;
        restart   = 1'b0;
        if (!sw_enable) begin
            st_nx = OFF;
        end else begin
            case (st)
                OFF:   st_nx = DELAY;
                DELAY: st_nx = dly_cnt == DW'(ENABLE_DELAY_C - 1) ? INIT : DELAY;
                INIT: begin
                    fatal_set = s1[6];
                    init_set  = !s1[1] && init_cnt == IW'(INIT_TIMEOUT_C - 1);
                    st_nx     = (fatal_set || init_set) ? FAULT : s1[1] ? OBSERVE : INIT;
                end
                OBSERVE: begin
                    fatal_set = s1[6];
                    hb_set    = !hb_edge && !phase && wd_cnt == HW'(HB_TIMEOUT_C - 1);
`ifdef SEM_SUPERVISOR_AUTO_RESTART_EN
                    restart   = hb_set && !fatal_set && restart_count != 2'd3;
`endif
                    st_nx     = fatal_set ? FAULT : !hb_set ? OBSERVE : restart ? DELAY : FAULT;
                end
                default: st_nx = st;
            endcase
        end
    end
    // state register, input synchroniser stages and per-state timers that clear on entry
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= OFF;
            s1       <= '0;
            s2       <= '0;
            dly_cnt  <= '0;
            init_cnt <= '0;
            wd_cnt   <= '0;
        end else begin
            st       <= st_nx;
            s1       <= sem_status[10:0];
            s2       <= {s1[10], s1[9], s1[7]};
            dly_cnt  <= (st == DELAY && st_nx == DELAY) ? dly_cnt + 1'b1 : '0;
            init_cnt <= (st == INIT && st_nx == INIT) ? init_cnt + 1'b1 : '0;
            wd_cnt   <= (st == OBSERVE && st_nx == OBSERVE && !hb_edge && !phase) ? wd_cnt + 1'b1 : '0;
        end
    end
    // saturating counters, sticky flags and irq; a set in the same cycle as clr_stats survives
    always_ff @(posedge clk) begin
        if (rst) begin
            corr_count    <= '0;
            uncorr_count  <= '0;
            init_timeout  <= 1'b0;
            hb_timeout    <= 1'b0;
            fatal_seen    <= 1'b0;
            irq           <= 1'b0;
            restart_count <= '0;
        end else begin
            corr_count    <= clr_stats ? CNT_W_C'(cor_evt) : corr_count + CNT_W_C'(cor_evt && !(&corr_count));
            uncorr_count  <= clr_stats ? CNT_W_C'(unc_evt) : uncorr_count + CNT_W_C'(unc_evt && !(&uncorr_count));
            init_timeout  <= init_set || (init_timeout && !clr_stats);
            hb_timeout    <= hb_set || (hb_timeout && !clr_stats);
            fatal_seen    <= fatal_set || (fatal_seen && !clr_stats);
            irq           <= fatal_set || init_set || hb_set || unc_evt || (irq && !clr_stats);
            restart_count <= clr_stats ? {1'b0, restart} : restart_count + {1'b0, restart};
        end
    end
endmodule

// File: tb/tb_sem_supervisor.sv
// tb_sem_supervisor: randomized self-checking bench for sem_supervisor with small timing parameters
module tb_sem_supervisor;
    localparam int ED = 16, IT = 200, HB = 64, CW = 4;
`ifdef SEM_SUPERVISOR_AUTO_RESTART_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, sw_enable, clr_stats;
    logic [13:0] sem_status;
    logic sem_enable, init_timeout, hb_timeout, fatal_seen, irq;
    logic [2:0] state;
    logic [CW-1:0] corr_count, uncorr_count;
    logic [1:0] rc;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    sem_supervisor #(.ENABLE_DELAY_C(ED), .INIT_TIMEOUT_C(IT), .HB_TIMEOUT_C(HB), .CNT_W_C(CW)) dut (
        .clk(clk), .rst(rst), .sw_enable(sw_enable), .clr_stats(clr_stats), .sem_status(sem_status),
        .sem_enable(sem_enable), .state(state), .corr_count(corr_count), .uncorr_count(uncorr_count),
        .init_timeout(init_timeout), .hb_timeout(hb_timeout), .fatal_seen(fatal_seen),
`ifdef SEM_SUPERVISOR_AUTO_RESTART_EN
        .restart_count(rc),
`endif
        .irq(irq)
    );
`ifndef SEM_SUPERVISOR_AUTO_RESTART_EN
    assign rc = 2'd0;
`endif

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sw_enable = 1'b0;
        clr_stats = 1'b0;
        sem_status = 14'($urandom) & 14'h3800;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic go_observe();
        do_reset();
        sw_enable = 1'b1;
        tick(ED + 1);
        sem_status[1] = 1'b1;
        tick(2);
    endtask

    task automatic pulse(input int b);
        sem_status[b] = 1'b1;
        tick($urandom_range(1, 3));
        sem_status[b] = 1'b0;
        tick($urandom_range(1, 3));
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({sem_enable, state, corr_count, uncorr_count, init_timeout, hb_timeout, fatal_seen, irq, rc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {sem_enable, state, corr_count, uncorr_count, init_timeout, hb_timeout, fatal_seen, irq, rc});
        end
    endtask

    task automatic test_bringup();
        int n;
        do_reset();
        sw_enable = 1'b1;
        tick(ED);
        checks++;
        if ({sem_enable, state} !== {1'b0, 3'd1}) begin
            errors++;
            $display("FAIL bringup_delay_end got en=%b st=%0d exp en=0 st=1", sem_enable, state);
        end
        tick(1);
        checks++;
        if ({sem_enable, state} !== {1'b1, 3'd2}) begin
            errors++;
            $display("FAIL bringup_init got en=%b st=%0d exp en=1 st=2", sem_enable, state);
        end
        n = $urandom_range(5, 60);
        tick(n);
        sem_status[1] = 1'b1;
        tick(1);
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL bringup_latency1 got=%0d exp=2", state);
        end
        tick(1);
        checks++;
        if ({state, init_timeout, hb_timeout, fatal_seen, irq} !== {3'd3, 4'b0}) begin
            errors++;
            $display("FAIL bringup_observe got st=%0d flags=%b exp st=3 flags=0000", state, {init_timeout, hb_timeout, fatal_seen, irq});
        end
    endtask

    task automatic test_heartbeat();
        int per, h;
        go_observe();
        for (int i = 0; i < 4; i++) begin
            per = (i == 0) ? HB : $urandom_range(8, HB);
            h = $urandom_range(1, per - 1);
            sem_status[7] = 1'b1;
            tick(h);
            sem_status[7] = 1'b0;
            tick(per - h);
            checks++;
            if (state !== 3'd3) begin
                errors++;
                $display("FAIL hb_alive[%0d] per=%0d got=%0d exp=3", i, per, state);
            end
        end
        sem_status[7] = 1'b1;
        tick(HB + 1);
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL hb_edge_of_window got=%0d exp=3", state);
        end
        tick(1);
        checks++;
        if ({state, sem_enable, hb_timeout, irq} !== {(AR ? 3'd1 : 3'd4), !AR, 2'b11}) begin
            errors++;
            $display("FAIL hb_timeout got st=%0d en=%b hb=%b irq=%b exp st=%0d en=%b hb=1 irq=1", state, sem_enable, hb_timeout, irq, AR ? 1 : 4, !AR);
        end
    endtask

    task automatic test_phase_hold();
        int b;
        go_observe();
        b = $urandom_range(2, 4);
        sem_status[b] = 1'b1;
        tick($urandom_range(100, 200));
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL phase_hold bit=%0d got=%0d exp=3", b, state);
        end
        sem_status[b] = 1'b0;
        tick(HB);
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL phase_release_early got=%0d exp=3", state);
        end
        tick(1);
        checks++;
        if ({state, hb_timeout} !== {(AR ? 3'd1 : 3'd4), 1'b1}) begin
            errors++;
            $display("FAIL phase_release_timeout got st=%0d hb=%b exp st=%0d hb=1", state, hb_timeout, AR ? 1 : 4);
        end
    endtask

    task automatic test_counting();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            sem_status[9] = $urandom_range(0, 1) == 1;
            pulse(10);
            sem_status[9] = 1'b0;
        end
        tick(3);
        checks++;
        if ({corr_count, uncorr_count, irq} !== {4'd15, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL count_saturate got corr=%0d uncorr=%0d irq=%b exp corr=15 uncorr=0 irq=0", corr_count, uncorr_count, irq);
        end
        sem_status[10] = 1'b1;
        tick(1);
        clr_stats = 1'b1;
        tick(1);
        clr_stats = 1'b0;
        sem_status[10] = 1'b0;
        tick(2);
        checks++;
        if (corr_count !== 4'd1) begin
            errors++;
            $display("FAIL count_clr_coincident got=%0d exp=1", corr_count);
        end
    endtask

    task automatic test_fatal_priority();
        do_reset();
        sw_enable = 1'b1;
        tick(ED + IT - 1);
        sem_status[6] = 1'b1;
        tick(1);
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL fatal_pre got=%0d exp=2", state);
        end
        tick(1);
        checks++;
        if ({state, fatal_seen, init_timeout, hb_timeout, irq} !== {3'd4, 4'b1101}) begin
            errors++;
            $display("FAIL fatal_and_init_to got st=%0d f=%b it=%b hb=%b irq=%b exp st=4 f=1 it=1 hb=0 irq=1", state, fatal_seen, init_timeout, hb_timeout, irq);
        end
        clr_stats = 1'b1;
        tick(1);
        clr_stats = 1'b0;
        checks++;
        if ({state, fatal_seen, init_timeout, irq} !== {3'd4, 3'b000}) begin
            errors++;
            $display("FAIL fault_clr got st=%0d flags=%b exp st=4 flags=000", state, {fatal_seen, init_timeout, irq});
        end
        sw_enable = 1'b0;
        tick(1);
        checks++;
        if ({state, sem_enable} !== 4'd0) begin
            errors++;
            $display("FAIL fault_disable got st=%0d en=%b exp st=0 en=0", state, sem_enable);
        end
        sem_status[6] = 1'b0;
    endtask

    task automatic test_fatal_observe();
        go_observe();
        tick($urandom_range(1, 40));
        sem_status[6] = 1'b1;
        tick(1);
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL fatal_obs_pre got=%0d exp=3", state);
        end
        tick(1);
        checks++;
        if ({state, fatal_seen, hb_timeout, init_timeout} !== {3'd4, 3'b100}) begin
            errors++;
            $display("FAIL fatal_obs got st=%0d f=%b hb=%b it=%b exp st=4 f=1 hb=0 it=0", state, fatal_seen, hb_timeout, init_timeout);
        end
    endtask

    task automatic test_random_stats();
        localparam int N = 120;
        bit p9[N], p10[N];
        int k, c9, c10;
        go_observe();
        sem_status[6] = 1'b1;
        tick(2);
        k = $urandom_range(20, 100);
        c9 = 0;
        c10 = 0;
        for (int j = 0; j < N; j++) begin
            p9[j] = $urandom_range(0, 3) == 0;
            p10[j] = $urandom_range(0, 3) == 0;
            if (j >= k - 1 && p9[j] && (j == 0 || !p9[j-1])) c9++;
            if (j >= k - 1 && p10[j] && (j == 0 || !p10[j-1])) c10++;
        end
        for (int j = 0; j < N; j++) begin
            sem_status[13:11] = 3'($urandom);
            sem_status[9] = p9[j];
            sem_status[10] = p10[j];
            clr_stats = (j == k);
            tick(1);
        end
        clr_stats = 1'b0;
        sem_status[10:9] = 2'b00;
        tick(3);
        checks++;
        if (corr_count !== CW'(c10 > 15 ? 15 : c10)) begin
            errors++;
            $display("FAIL rand_corr got=%0d exp=%0d", corr_count, c10 > 15 ? 15 : c10);
        end
        checks++;
        if (uncorr_count !== CW'(c9 > 15 ? 15 : c9)) begin
            errors++;
            $display("FAIL rand_uncorr got=%0d exp=%0d", uncorr_count, c9 > 15 ? 15 : c9);
        end
        checks++;
        if ({irq, fatal_seen, state} !== {c9 > 0, 1'b0, 3'd4}) begin
            errors++;
            $display("FAIL rand_flags got irq=%b f=%b st=%0d exp irq=%b f=0 st=4", irq, fatal_seen, state, c9 > 0);
        end
        sem_status[6] = 1'b0;
    endtask

    task automatic test_mid_reset();
        go_observe();
        for (int i = 0; i < 3; i++) pulse(10);
        for (int i = 0; i < 2; i++) pulse(9);
        tick(2);
        checks++;
        if ({corr_count, uncorr_count, irq} !== {4'd3, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL midrst_pre got corr=%0d uncorr=%0d irq=%b exp 3 2 1", corr_count, uncorr_count, irq);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if ({sem_enable, state, corr_count, uncorr_count, init_timeout, hb_timeout, fatal_seen, irq, rc} !== '0) begin
            errors++;
            $display("FAIL midrst_clear got=%b exp=0", {sem_enable, state, corr_count, uncorr_count, init_timeout, hb_timeout, fatal_seen, irq, rc});
        end
        tick(1);
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL midrst_redelay got=%0d exp=1", state);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int t = 0;
        while (state !== s && t < 300) begin
            tick(1);
            t++;
        end
        checks++;
        if (state !== s) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, state, s);
        end
    endtask

    task automatic test_auto_restart();
        go_observe();
        for (int r = 1; r <= 3; r++) begin
            wait_state(3'd1, "ar_delay");
            checks++;
            if ({rc, sem_enable, hb_timeout, irq} !== {2'(r), 3'b011}) begin
                errors++;
                $display("FAIL ar_restart[%0d] got rc=%0d en=%b hb=%b irq=%b exp rc=%0d en=0 hb=1 irq=1", r, rc, sem_enable, hb_timeout, irq, r);
            end
            wait_state(3'd2, "ar_rearm");
            checks++;
            if (sem_enable !== 1'b1) begin
                errors++;
                $display("FAIL ar_enable[%0d] got=%b exp=1", r, sem_enable);
            end
        end
        wait_state(3'd4, "ar_fourth_fault");
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_heartbeat();
        test_phase_hold();
        test_counting();
        test_fatal_priority();
        test_fatal_observe();
        test_random_stats();
        test_mid_reset();
        if (AR) test_auto_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
